// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus arbiter: peripheral selects, master IDs
// and the default depth of the outstanding-transaction ID FIFO.
package bus_pkg;

    typedef enum logic [2:0] {
        PERIPH_UART  = 3'b000,
        PERIPH_I2C   = 3'b001,
        PERIPH_QSPI  = 3'b010,
        PERIPH_TIMER = 3'b011,
        PERIPH_USB   = 3'b100,
        PERIPH_GPIO  = 3'b101
    } periph_sel_e;

    localparam int BUFFER_POW_DEF = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO holding the IDs of outstanding bus transactions.
// Pointers are POW bits and wrap naturally; count is POW+1 bits.
module id_fifo #(
    parameter int POW = 4,
    parameter int W   = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [POW:0] count_o
);

    localparam int DEPTH = 1 << POW;
    localparam logic [POW-1:0] PTR_ONE = {{(POW-1){1'b0}}, 1'b1};
    localparam logic [POW:0]   CNT_ONE = {{POW{1'b0}}, 1'b1};

    logic [W-1:0]   mem [DEPTH];
    logic [POW-1:0] wr_ptr_q, rd_ptr_q;
    logic [POW:0]   count_q;
    logic           do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full_o  = count_q[POW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter in front of the data bus, routing responses
// back via an ID FIFO. Optional exclusive lock: define BUS_ARB_LOCK_EN.
//
// state (ptr_q) | meaning
// M0            | master 0 wins when both request
// M1            | master 1 wins when both request
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int BUFFER_POW = BUFFER_POW_DEF,
    parameter int ADDR_W     = 14
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m1_req_i,
    input  logic              m0_we_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m0_be_i,
    input  logic [3:0]        m1_be_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m0_wdata_i,
    input  logic [31:0]       m1_wdata_i,
`ifdef BUS_ARB_LOCK_EN
    input  logic              m0_lock_i,
    input  logic              m1_lock_i,
`endif
    output logic              m0_gnt_o,
    output logic              m1_gnt_o,
    output logic              m0_rvalid_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    output logic [31:0]       m1_rdata_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic              busy_o,
    output logic              err_o
);

    logic              ptr_q, ptr_d;
    logic              gnt0, gnt1, grant, winner;
    logic              fifo_full, fifo_empty, fifo_head, pop;
    logic [BUFFER_POW:0] fifo_count;

    logic              sel_we;
    logic [3:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              m0_rvalid_q, m1_rvalid_q, err_q;
    logic [31:0]       m0_rdata_q, m1_rdata_q;

`ifdef BUS_ARB_LOCK_EN
    logic lock_q, lock_d, lock_id_q, lock_id_d, hold, winner_lock;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= M0;
`ifdef BUS_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= M0;
`endif
        end else begin
            ptr_q     <= ptr_d;
`ifdef BUS_ARB_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef BUS_ARB_LOCK_EN
        lock_id_d = lock_id_q;
        lock_d    = 1'b0;
        if (grant) begin
            lock_d    = winner_lock;
            lock_id_d = winner;
            // pointer is frozen only while an established lock is being held
            if (!hold) ptr_d = other_id(winner);
        end
`else
        if (grant) ptr_d = other_id(winner);
`endif
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        hold = lock_q && !fifo_full &&
               ((lock_id_q == M0) ? (m0_lock_i && m0_req_i) : (m1_lock_i && m1_req_i));
`endif
        if (!fifo_full) begin
`ifdef BUS_ARB_LOCK_EN
            if (hold) begin
                gnt0 = (lock_id_q == M0);
                gnt1 = (lock_id_q == M1);
            end else
`endif
            if (m0_req_i && (!m1_req_i || ptr_q == M0)) begin
                gnt0 = 1'b1;
            end else if (m1_req_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign grant  = gnt0 || gnt1;
    assign winner = gnt1 ? M1 : M0;
`ifdef BUS_ARB_LOCK_EN
    assign winner_lock = (winner == M1) ? m1_lock_i : m0_lock_i;
`endif

    always_comb begin
        sel_we    = (winner == M1) ? m1_we_i    : m0_we_i;
        sel_be    = (winner == M1) ? m1_be_i    : m0_be_i;
        sel_addr  = (winner == M1) ? m1_addr_i  : m0_addr_i;
        sel_wdata = (winner == M1) ? m1_wdata_i : m0_wdata_i;
    end

    // shadow of the last granted fields keeps the bus quiet between grants
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            we_q    <= sel_we;
            be_q    <= sel_be;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign m0_gnt_o     = gnt0;
    assign m1_gnt_o     = gnt1;
    assign data_req_o   = grant;
    assign data_we_o    = grant ? sel_we    : we_q;
    assign data_be_o    = grant ? sel_be    : be_q;
    assign data_addr_o  = grant ? sel_addr  : addr_q;
    assign data_wdata_o = grant ? sel_wdata : wdata_q;

    assign pop = data_rvalid_i && !fifo_empty;

    id_fifo #(
        .POW (BUFFER_POW),
        .W   (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            if (data_rvalid_i) begin
                if (fifo_empty) begin
                    err_q <= 1'b1;
                end else if (fifo_head == M1) begin
                    m1_rvalid_q <= 1'b1;
                    m1_rdata_q  <= data_rdata_i;
                end else begin
                    m0_rvalid_q <= 1'b1;
                    m0_rdata_q  <= data_rdata_i;
                end
            end
        end
    end

    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign err_o       = err_q;
    assign busy_o      = (fifo_count != '0);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; the lock scenario runs when BUS_ARB_LOCK_EN is defined.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [13:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_lock, m1_lock;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [13:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        busy, err;

    int n_cmp = 0;
    int n_err = 0;
    int g0, g1, j;

    always #5 clk = ~clk;

    bus_arbiter #(.BUFFER_POW(4), .ADDR_W(14)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m0_req_i      (m0_req),
        .m1_req_i      (m1_req),
        .m0_we_i       (m0_we),
        .m1_we_i       (m1_we),
        .m0_be_i       (m0_be),
        .m1_be_i       (m1_be),
        .m0_addr_i     (m0_addr),
        .m1_addr_i     (m1_addr),
        .m0_wdata_i    (m0_wdata),
        .m1_wdata_i    (m1_wdata),
`ifdef BUS_ARB_LOCK_EN
        .m0_lock_i     (m0_lock),
        .m1_lock_i     (m1_lock),
`endif
        .m0_gnt_o      (m0_gnt),
        .m1_gnt_o      (m1_gnt),
        .m0_rvalid_o   (m0_rvalid),
        .m1_rvalid_o   (m1_rvalid),
        .m0_rdata_o    (m0_rdata),
        .m1_rdata_o    (m1_rdata),
        .data_req_o    (data_req),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_addr_o   (data_addr),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata),
        .busy_o        (busy),
        .err_o         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_be = 4'h0; m1_be = 4'h0; m0_addr = '0; m1_addr = '0;
        m0_wdata = '0; m1_wdata = '0; m0_lock = 0; m1_lock = 0;
        data_rvalid = 0; data_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #3;
        check("rst_req", data_req, 0);
        check("rst_addr", data_addr, 0);
        check("rst_rvalid0", m0_rvalid, 0);
        check("rst_rvalid1", m1_rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1;

        // single m0 read, response one cycle later
        m0_req = 1; m0_addr = 14'h0010; m0_be = 4'hF;
        #1;
        check("t1_gnt0", m0_gnt, 1);
        check("t1_gnt1", m1_gnt, 0);
        check("t1_req", data_req, 1);
        check("t1_addr", data_addr, 14'h0010);
        tick();
        m0_req = 0; data_rvalid = 1; data_rdata = 32'hDEADBEEF;
        #1;
        check("t1_req_idle", data_req, 0);
        check("t1_addr_hold", data_addr, 14'h0010);
        check("t1_busy", busy, 1);
        tick();
        data_rvalid = 0;
        check("t1_rvalid0", m0_rvalid, 1);
        check("t1_rdata0", m0_rdata, 32'hDEADBEEF);
        check("t1_rvalid1", m1_rvalid, 0);
        check("t1_busy_clr", busy, 0);
        check("t1_err", err, 0);

        // both masters request continuously; responses one cycle behind
        do_reset();
        g0 = 0; g1 = 0;
        m0_addr = 14'h0100; m1_addr = 14'h0200;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                j = i - 2;
                if (j % 2 == 0) begin
                    check("rr_rvalid0", m0_rvalid, 1);
                    check("rr_rvalid1_idle", m1_rvalid, 0);
                    check("rr_rdata0", m0_rdata, 32'hA000_0000 + 32'(j));
                    if (j > 0) check("rr_hold1", m1_rdata, 32'hA000_0000 + 32'(j - 1));
                end else begin
                    check("rr_rvalid1", m1_rvalid, 1);
                    check("rr_rvalid0_idle", m0_rvalid, 0);
                    check("rr_rdata1", m1_rdata, 32'hA000_0000 + 32'(j));
                    check("rr_hold0", m0_rdata, 32'hA000_0000 + 32'(j - 1));
                end
            end
            m0_req = (i < 8);
            m1_req = (i < 8);
            data_rvalid = (i >= 1 && i <= 8);
            data_rdata = 32'hA000_0000 + 32'(i - 1);
            #1;
            if (i < 8) begin
                check("rr_gnt0", m0_gnt, (i % 2 == 0));
                check("rr_gnt1", m1_gnt, (i % 2 == 1));
                check("rr_addr", data_addr, (i % 2 == 0) ? 14'h0100 : 14'h0200);
                if (m0_gnt) g0++;
                if (m1_gnt) g1++;
            end
            tick();
        end
        check("rr_count0", g0, 4);
        check("rr_count1", g1, 4);
        check("rr_busy", busy, 0);

        // fill the FIFO from m1 with no responses
        do_reset();
        for (int i = 0; i < 16; i++) begin
            m1_req = 1; m1_addr = 14'(i);
            #1;
            check("full_gnt", m1_gnt, 1);
            tick();
        end
        #1;
        check("full_no_gnt", m1_gnt, 0);
        check("full_no_req", data_req, 0);
        check("full_addr_hold", data_addr, 14'd15);
        check("full_busy", busy, 1);
        tick();
        data_rvalid = 1;
        #1;
        check("full_pop_same_cycle", m1_gnt, 0);
        tick();
        data_rvalid = 0;
        check("full_rvalid1", m1_rvalid, 1);
        #1;
        check("full_regrant", m1_gnt, 1);
        tick();
        m1_req = 0;

        // stray response while idle
        do_reset();
        data_rvalid = 1; data_rdata = 32'h1234_5678;
        tick();
        data_rvalid = 0;
        check("stray_rvalid0", m0_rvalid, 0);
        check("stray_rvalid1", m1_rvalid, 0);
        check("stray_err", err, 1);
        tick();
        tick();
        check("stray_err_sticky", err, 1);

        // reset with 5 outstanding
        do_reset();
        check("err_cleared", err, 0);
        m0_req = 1; m0_addr = 14'h0123; m0_we = 1; m0_be = 4'h3; m0_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) tick();
        m0_req = 0;
        check("flush_busy_before", busy, 1);
        check("flush_shadow_before", data_addr, 14'h0123);
        rst_n = 0;
        #1;
        check("flush_busy", busy, 0);
        check("flush_req", data_req, 0);
        check("flush_addr", data_addr, 0);
        check("flush_we", data_we, 0);
        check("flush_be", data_be, 0);
        check("flush_wdata", data_wdata, 0);
        check("flush_gnt0", m0_gnt, 0);
        @(negedge clk);
        rst_n = 1;
        check("flush_busy_after", busy, 0);
        data_rvalid = 1;
        tick();
        data_rvalid = 0;
        check("flush_late_rvalid0", m0_rvalid, 0);
        check("flush_late_err", err, 1);

`ifdef BUS_ARB_LOCK_EN
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_gnt0", m0_gnt, 1);
            check("lock_gnt1", m1_gnt, 0);
            tick();
        end
        m0_lock = 0;
        #1;
        check("unlock_gnt1", m1_gnt, 1);
        check("unlock_gnt0", m0_gnt, 0);
        tick();
        clear_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter in front of the shared data bus (data memory plus UART/I2C/QSPI/timer/USB/GPIO windows).
- Requester 0 is the core LSU data port; requester 1 is a secondary master (DMA/debug).
- Round-robin grant with an outstanding-transaction ID FIFO, so each bus rvalid/rdata is routed back to the requester that issued it.
- Sits between the masters and the bus block; the bus block itself is unchanged.

Parameters:
- BUFFER_POW, 4, log2 of the outstanding-ID FIFO depth (DEPTH = 2^BUFFER_POW).
- ADDR_W, 14, request address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m0_req_i, m1_req_i  in  1  request valid per master.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_be_i, m1_be_i  in  4  byte enables.
- m0_addr_i, m1_addr_i  in  ADDR_W  address.
- m0_wdata_i, m1_wdata_i  in  32  write data.
- m0_gnt_o, m1_gnt_o  out  1  request accepted this cycle.
- m0_rvalid_o, m1_rvalid_o  out  1  response valid.
- m0_rdata_o, m1_rdata_o  out  32  response data.
- data_req_o  out  1  bus request.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  bus byte enables.
- data_addr_o  out  ADDR_W  bus address.
- data_wdata_o  out  32  bus write data.
- data_rvalid_i  in  1  bus response valid.
- data_rdata_i  in  32  bus response data.
- busy_o  out  1  outstanding count non-zero.
- err_o  out  1  sticky: rvalid received with FIFO empty.

Behaviour:
- Reset (rst_ni low, async):
  - All outputs 0.
  - FIFO empty; count = 0.
  - Priority pointer = master 0.
  - err_o cleared.
- Transaction model: every accepted request (read or write) yields exactly one data_rvalid_i, in order, latency ≥1 cycle.
- Arbitration:
  - Combinational, same cycle as the request.
  - Eligible when count < DEPTH. Full blocks acceptance even if a pop occurs in the same cycle.
  - One master requesting: it wins.
  - Both requesting: the master at the priority pointer wins.
  - Pointer moves to the other master after any grant (round-robin; switches only on grant).
- On grant:
  - mX_gnt_o = 1 and data_req_o = 1.
  - Bus fields are muxed combinationally from the winner.
  - The winner's ID bit is pushed into the FIFO at the clock edge.
- No grant: data_req_o = 0; bus fields hold the last granted values (registered shadow, no toggling).
- Masters keep req and fields stable until gnt.
- Response routing:
  - On data_rvalid_i, pop the FIFO head ID.
  - Registered, 1-cycle latency: next cycle m{ID}_rvalid_o = 1 and m{ID}_rdata_o = data_rdata_i.
  - The other master's rvalid stays 0 and its rdata holds.
- Simultaneous push and pop: count unchanged; pointers advance; push into the wrapped slot is legal.
- Pointer wrap: read/write pointers are BUFFER_POW bits and wrap naturally. count is BUFFER_POW+1 bits.
- rvalid with count = 0: response dropped (no mX_rvalid_o); err_o set until reset.
- busy_o = (count != 0), registered.
- Reset mid-operation: FIFO flushed; responses arriving after reset with count = 0 set err_o.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- With it defined:
  - Adds input ports m0_lock_i and m1_lock_i.
  - A granted master asserting lock keeps exclusive grant. The other master is not granted and the pointer does not move while lock stays high with req.
  - Lock releases on the first cycle lock_i is low.
  - Lock is ignored while the FIFO is full.
- Without it: pure round-robin; no lock ports.

Decomposition:
- Shared package bus_pkg:
  - Peripheral select constants (UART = 3'b000 … GPIO = 3'b101).
  - BUFFER_POW default.
  - Master ID localparams M0 = 1'b0, M1 = 1'b1.
- Sub-module id_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, async active-low reset. Instantiated once for the IDs.

Test Plan:
- Only m0 issues a read to addr 14'h0010, bus returns rdata 32'hDEADBEEF one cycle later -> m0_gnt_o same cycle; m0_rvalid_o with 32'hDEADBEEF next cycle; m1_rvalid_o stays 0.
- m0 and m1 request continuously for 8 cycles with instant responses -> grants alternate m0, m1, m0 … (4 each); rvalids routed in the same order.
- m1 issues 16 requests with no responses -> 16 grants; 17th request gets no gnt and data_req_o = 0. One rvalid arrives -> next request granted.
- rvalid pulse while idle after reset -> no mX_rvalid_o; err_o = 1 and stays high until rst_ni low.
- Reset asserted with 5 outstanding, then released -> busy_o = 0 and count = 0 immediately; all outputs 0.
- With BUS_ARB_LOCK_EN: m0 locks for 3 grants while m1 requests -> m0 granted 3 times, then m1 granted the cycle after lock drops.
